// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle controller and the processor datapath.
// master = controller side (reads opcode/mem_ready/zero, drives strobes).
// slave  = datapath side.
interface controle_multiciclo_if #(
    parameter int OP_W = 4
);
    logic [OP_W-1:0] opcode;
    logic            mem_ready;
    logic            zero;

    logic            LeMem;
    logic            EscIR;
    logic            EscCondCP;
    logic            EscCP;
    logic [OP_W-1:0] ULA_OP;
    logic            ULA_A;
    logic [1:0]      ULA_B;
    logic [1:0]      FonteCP;
    logic            EscReg;
    logic            instr_fim;
    logic            halted;

    modport master (
        input  opcode, mem_ready, zero,
        output LeMem, EscIR, EscCondCP, EscCP, ULA_OP, ULA_A, ULA_B,
               FonteCP, EscReg, instr_fim, halted
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  LeMem, EscIR, EscCondCP, EscCP, ULA_OP, ULA_A, ULA_B,
               FonteCP, EscReg, instr_fim, halted
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the processor datapath.
// States: FETCH -> DECODE -> (EXEC x EXEC_CYCLES -> WB -> PC | JUMP | BRANCH | PC).
// The opcode is latched on the DECODE edge, so the opcode port is ignored
// for the rest of the instruction. Outputs are a Moore decode of state and
// latched opcode; only LeMem/EscIR look at inputs (mem_ready, rst_n) in FETCH.
// Optional feature: define CTRL_HALT_EN to turn opcode 15 into a HALT that
// holds halted=1 until reset. Without it opcode 15 is a NOP and halted is 0.
// OP_W must be at least 4; opcodes above 15 decode as NOP.
module controle_multiciclo #(
    parameter int OP_W        = 4,
    parameter int EXEC_CYCLES = 2   // legal 1..15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    controle_multiciclo_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_PC,
        S_JUMP,
        S_BRANCH
`ifdef CTRL_HALT_EN
        ,
        S_HALT,
        S_HALT_WAIT
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_JMP,
        CLS_BR,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    // Instruction class of a 4-bit opcode.
    function automatic op_class_t class_of(input logic [3:0] op);
        op_class_t cls;
        case (op)
            4'd0, 4'd1, 4'd3, 4'd4, 4'd5:          cls = CLS_R;
            4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:   cls = CLS_I;
            4'd11:                                 cls = CLS_JMP;
            4'd12:                                 cls = CLS_BR;
`ifdef CTRL_HALT_EN
            4'd15:                                 cls = CLS_HALT;
`endif
            default:                               cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    state_t          state_reg, state_next;
    logic [OP_W-1:0] op_reg, op_next;
    logic [3:0]      counter_reg, counter_next;

    // Constant decode table for the 16 low opcodes.
    op_class_t class_rom [16];
    for (genvar gi = 0; gi < 16; gi++) begin : g_class_rom
        assign class_rom[gi] = class_of(4'(gi));
    end

    // Opcodes with any bit above bit 3 set fall outside the table.
    logic opcode_high;
    logic op_reg_high;
    if (OP_W > 4) begin : g_wide_op
        assign opcode_high = |bus.opcode[OP_W-1:4];
        assign op_reg_high = |op_reg[OP_W-1:4];
    end else begin : g_narrow_op
        assign opcode_high = 1'b0;
        assign op_reg_high = 1'b0;
    end

    op_class_t cls_in;    // class of the opcode port (used only in DECODE)
    op_class_t cls_reg;   // class of the latched opcode
    assign cls_in  = opcode_high ? CLS_NOP : class_rom[bus.opcode[3:0]];
    assign cls_reg = op_reg_high ? CLS_NOP : class_rom[op_reg[3:0]];

    // The branch flag is consumed by the datapath, not by the controller.
    logic unused_zero;
    assign unused_zero = bus.zero;

    logic            le_mem;
    logic            esc_ir;
    logic            esc_cond_cp;
    logic            esc_cp;
    logic [OP_W-1:0] ula_op;
    logic            ula_a;
    logic [1:0]      ula_b;
    logic [1:0]      fonte_cp;
    logic            esc_reg;
    logic            instr_fim;
    logic            halted;

    // State, latched opcode and execute counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            op_reg      <= '0;
            counter_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            counter_reg <= counter_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        counter_next = counter_reg;
        le_mem       = 1'b0;
        esc_ir       = 1'b0;
        esc_cond_cp  = 1'b0;
        esc_cp       = 1'b0;
        ula_op       = op_reg;
        ula_a        = 1'b0;
        ula_b        = 2'b00;
        fonte_cp     = 2'b00;
        esc_reg      = 1'b0;
        instr_fim    = 1'b0;
        halted       = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // A held reset keeps the fetch request quiet.
                ula_op = '0;
                le_mem = rst_n;
                if (bus.mem_ready) begin
                    esc_ir     = rst_n;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                op_next = bus.opcode;
                ula_a   = 1'b0;
                ula_b   = 2'b01;   // CP + 1 precompute
                case (cls_in)
                    CLS_R, CLS_I: begin
                        state_next   = S_EXEC;
                        counter_next = EXEC_LOAD;
                    end
                    CLS_JMP:  state_next = S_JUMP;
                    CLS_BR:   state_next = S_BRANCH;
`ifdef CTRL_HALT_EN
                    CLS_HALT: state_next = S_HALT;
`endif
                    default:  state_next = S_PC;
                endcase
            end

            S_EXEC: begin
                ula_a = 1'b1;
                ula_b = (cls_reg == CLS_I) ? 2'b10 : 2'b00;
                if (counter_reg == 4'd0) begin
                    state_next = S_WB;
                end else begin
                    counter_next = counter_reg - 4'd1;
                end
            end

            S_WB: begin
                // ULA selects held so the result stays stable while written.
                esc_reg    = 1'b1;
                ula_a      = 1'b1;
                ula_b      = (cls_reg == CLS_I) ? 2'b10 : 2'b00;
                state_next = S_PC;
            end

            S_PC: begin
                esc_cp     = 1'b1;
                fonte_cp   = 2'b00;
                instr_fim  = 1'b1;
                state_next = S_FETCH;
            end

            S_JUMP: begin
                esc_cp     = 1'b1;
                fonte_cp   = 2'b10;
                ula_a      = 1'b0;
                ula_b      = 2'b10;
                instr_fim  = 1'b1;
                state_next = S_FETCH;
            end

            S_BRANCH: begin
                // The datapath qualifies this write with the zero flag.
                esc_cond_cp = 1'b1;
                fonte_cp    = 2'b01;
                ula_a       = 1'b1;
                ula_b       = 2'b00;
                instr_fim   = 1'b1;
                state_next  = S_FETCH;
            end

`ifdef CTRL_HALT_EN
            S_HALT: begin
                // Entry cycle: the halting instruction completes here.
                halted     = 1'b1;
                instr_fim  = 1'b1;
                state_next = S_HALT_WAIT;
            end

            S_HALT_WAIT: begin
                halted     = 1'b1;
                state_next = S_HALT_WAIT;
            end
`endif

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign bus.LeMem     = le_mem;
    assign bus.EscIR     = esc_ir;
    assign bus.EscCondCP = esc_cond_cp;
    assign bus.EscCP     = esc_cp;
    assign bus.ULA_OP    = ula_op;
    assign bus.ULA_A     = ula_a;
    assign bus.ULA_B     = ula_b;
    assign bus.FonteCP   = fonte_cp;
    assign bus.EscReg    = esc_reg;
    assign bus.instr_fim = instr_fim;
    assign bus.halted    = halted;

endmodule
